// File: rtl/adder_inverse.sv
// Recovers operand a from a registered adder sum by subtracting the known addend b,
// one CHUNK_WIDTH slice per clock, LSB first, with the borrow carried between slices.
module adder_inverse #(
    parameter int unsigned ADDER_WIDTH = 33,
    parameter int unsigned CHUNK_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDER_WIDTH:0]   sum,
    input  logic [ADDER_WIDTH-1:0] b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDER_WIDTH-1:0] a,
    output logic                   overflow
);

    localparam int unsigned NumChunks = (ADDER_WIDTH + CHUNK_WIDTH) / CHUNK_WIDTH;
    localparam int unsigned PadWidth  = NumChunks * CHUNK_WIDTH;
    localparam int unsigned IdxWidth  = (NumChunks > 1) ? $clog2(NumChunks) : 1;
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumChunks - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e                state_q;
    logic [PadWidth-1:0]   sum_q;
    logic [PadWidth-1:0]   b_q;
    logic [PadWidth-1:0]   res_q;
    logic                  borrow_q;
    logic [IdxWidth-1:0]   idx_q;

    logic [CHUNK_WIDTH:0]  diff;
    logic [PadWidth-1:0]   res_next;

    // Operands shift right each cycle, so the active slice is always the low chunk;
    // result slices enter at the top and land in place after the last slice.
    always_comb begin
        diff = {1'b0, sum_q[CHUNK_WIDTH-1:0]} - {1'b0, b_q[CHUNK_WIDTH-1:0]}
               - {{CHUNK_WIDTH{1'b0}}, borrow_q};
        res_next = res_q >> CHUNK_WIDTH;
        res_next[PadWidth-1 -: CHUNK_WIDTH] = diff[CHUNK_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a         <= '0;
            overflow  <= 1'b0;
            sum_q     <= '0;
            b_q       <= '0;
            res_q     <= '0;
            borrow_q  <= 1'b0;
            idx_q     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        sum_q    <= PadWidth'(sum);
                        b_q      <= PadWidth'(b);
                        res_q    <= '0;
                        borrow_q <= 1'b0;
                        idx_q    <= '0;
                        in_ready <= 1'b0;
                        state_q  <= StCalc;
                    end
                end
                StCalc: begin
                    sum_q    <= sum_q >> CHUNK_WIDTH;
                    b_q      <= b_q >> CHUNK_WIDTH;
                    res_q    <= res_next;
                    borrow_q <= diff[CHUNK_WIDTH];
                    idx_q    <= idx_q + IdxWidth'(1);
                    if (idx_q == LastIdx) begin
                        a         <= res_next[ADDER_WIDTH-1:0];
                        // Negative result or any bit above the a field is unrepresentable.
                        overflow  <= diff[CHUNK_WIDTH] | (|res_next[PadWidth-1:ADDER_WIDTH]);
                        out_valid <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_inverse.sv
// Directed bench for adder_inverse: reset state, known subtraction vectors, round trips,
// backpressure, and reset during calculation and during result hold.
module tb_adder_inverse;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [33:0] sum;
    logic [32:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [32:0] a;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adder_inverse #(
        .ADDER_WIDTH(33),
        .CHUNK_WIDTH(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sum      (sum),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .a        (a),
        .overflow (overflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [33:0] s, input logic [32:0] bb);
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("accept_ready", 64'(in_ready), 64'd1);
        sum      = s;
        b        = bb;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd5);
    endtask

    task automatic finish_op(input string tag, input logic [32:0] exp_a, input logic exp_o);
        check({tag, "_a"}, 64'(a), 64'(exp_a));
        check({tag, "_ovf"}, 64'(overflow), 64'(exp_o));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_ready_after"}, 64'(in_ready), 64'd1);
        check({tag, "_valid_after"}, 64'(out_valid), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [33:0] s, input logic [32:0] bb,
                          input logic [32:0] exp_a, input logic exp_o);
        start_op(s, bb);
        wait_done(tag);
        finish_op(tag, exp_a, exp_o);
    endtask

    initial begin
        logic [31:0] r1, r2, r3, r4;
        logic [32:0] ra, rb;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sum       = '0;
        b         = '0;
        step();
        step();
        reset = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_a", 64'(a), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);

        run_op("borrow_chain", 34'h1_0000_0000, 33'h0_0000_0001, 33'h0_FFFF_FFFF, 1'b0);
        run_op("negative", 34'h0_0000_0003, 33'h0_0000_0005, 33'h1_FFFF_FFFE, 1'b1);
        run_op("top_bit", 34'h3_FFFF_FFFF, 33'h0_0000_0000, 33'h1_FFFF_FFFF, 1'b1);
        run_op("max_trip", 34'h3_FFFF_FFFE, 33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF, 1'b0);
        run_op("equal", 34'h0_0000_0005, 33'h0_0000_0005, 33'h0_0000_0000, 1'b0);

        for (int i = 0; i < 2000; i++) begin
            r1 = $urandom;
            r2 = $urandom;
            r3 = $urandom;
            r4 = $urandom;
            ra = {r2[0], r1};
            rb = {r4[0], r3};
            run_op("round_trip", {1'b0, ra} + {1'b0, rb}, rb, ra, 1'b0);
        end

        // Inputs change during CALC and in_valid pulses during DONE; neither may disturb it.
        start_op(34'h0_0000_1234, 33'h0_0000_0234);
        sum = '1;
        b   = '0;
        wait_done("bp");
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0);
            sum      = {2'b01, $urandom};
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_a", 64'(a), 64'h1000);
            check("bp_ovf", 64'(overflow), 64'd0);
            step();
        end
        in_valid = 1'b0;
        finish_op("bp", 33'h0_0000_1000, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step();
            check("bp_no_extra_op", 64'(out_valid), 64'd0);
        end

        // Reset during the second CALC cycle discards the operation.
        start_op(34'h0_0000_0010, 33'h0_0000_0001);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rc_in_ready", 64'(in_ready), 64'd1);
        check("rc_out_valid", 64'(out_valid), 64'd0);
        check("rc_a", 64'(a), 64'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            check("rc_no_result", 64'(out_valid), 64'd0);
        end

        // out_ready held high through CALC must not shorten the latency.
        start_op(34'h2_0000_0000, 33'h1_0000_0000);
        out_ready = 1'b1;
        wait_done("ordy");
        finish_op("ordy", 33'h1_0000_0000, 1'b0);

        // Reset while a result is held discards it.
        start_op(34'h0_0000_0001, 33'h0_0000_0002);
        wait_done("rd");
        check("rd_ovf_before", 64'(overflow), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rd_out_valid", 64'(out_valid), 64'd0);
        check("rd_in_ready", 64'(in_ready), 64'd1);
        check("rd_a", 64'(a), 64'd0);
        check("rd_ovf", 64'(overflow), 64'd0);

        run_op("after_rst", 34'h0_0001_0000, 33'h0_0000_0001, 33'h0_0000_FFFF, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
